adc_ltc2308_ctrl: RTL and testbench

- Fabric-side SPI-style initiator for the on-board LTC2308 12-bit ADC.
- Drives ADC_CONVST, ADC_SCK and ADC_SDI, and reads ADC_SDO.
- Accepts one conversion request at a time (channel, mode) over a valid/ready handshake and returns a 12-bit result with a 1-cycle valid pulse.
- The LTC2308 applies a config word to the next conversion. The block hides this by issuing a discarded priming frame whenever the requested config differs from the last config loaded into the ADC.

---
 rtl/adc_ltc2308_pkg.sv | 38 +++
 rtl/ltc2308_shifter.sv | 79 +++++++
 rtl/adc_ltc2308_ctrl.sv | 152 +++++++++++++++
 tb/tb_adc_ltc2308_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ltc2308_pkg.sv
// Shared types and constants for the LTC2308 ADC controller: FSM states,
// frame geometry and the 6-bit configuration word layout.
package adc_ltc2308_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        ACQ   = 2'd3
    } state_e;

    localparam int FRAME_BITS = 12;
    localparam int CFG_BITS   = 6;

    // Bit positions inside the config word (shifted out MSB first).
    localparam int CFG_SD_POS  = 5;
    localparam int CFG_OS_POS  = 4;
    localparam int CFG_S1_POS  = 3;
    localparam int CFG_S0_POS  = 2;
    localparam int CFG_UNI_POS = 1;
    localparam int CFG_SLP_POS = 0;

    // Build the LTC2308 config word; sleep is never requested.
    function automatic logic [CFG_BITS-1:0] pack_cfg(input logic [2:0] ch,
                                                     input logic       sgl,
                                                     input logic       uni);
        logic [CFG_BITS-1:0] cfg;
        cfg              = {CFG_BITS{1'b0}};
        cfg[CFG_SD_POS]  = sgl;
        cfg[CFG_OS_POS]  = ch[0];
        cfg[CFG_S1_POS]  = ch[2];
        cfg[CFG_S0_POS]  = ch[1];
        cfg[CFG_UNI_POS] = uni;
        cfg[CFG_SLP_POS] = 1'b0;
        return cfg;
    endfunction

endpackage

// File: rtl/ltc2308_shifter.sv
// SCK generator and 12-bit full-duplex shifter for one LTC2308 frame.
// Each bit is a low phase then a high phase of CLK_DIV clocks; SDI changes
// at the start of the low phase and SDO is captured on the clock where SCK
// rises. done_o is high in the final clock of the last high phase.
module ltc2308_shifter
    import adc_ltc2308_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [CFG_BITS-1:0]   cfg_i,
    input  logic                  sdo_i,
    output logic                  done_o,
    output logic                  sck_o,
    output logic                  sdi_o,
    output logic [FRAME_BITS-1:0] rx_data_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [PW-1:0] PHASE_RELOAD = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT     = BW'(FRAME_BITS - 1);

    logic                  active_q;
    logic                  sck_q;
    logic                  sdi_q;
    logic [PW-1:0]         phase_q;
    logic [BW-1:0]         bit_q;
    logic [FRAME_BITS-2:0] tx_q;
    logic [FRAME_BITS-1:0] rx_q;

    assign done_o    = active_q && sck_q && (phase_q == {PW{1'b0}}) && (bit_q == LAST_BIT);
    assign sck_o     = sck_q;
    assign sdi_o     = sdi_q;
    assign rx_data_o = rx_q;

    // Phase/bit sequencing with SDI launch and SDO capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            phase_q  <= {PW{1'b0}};
            bit_q    <= {BW{1'b0}};
            tx_q     <= {(FRAME_BITS-1){1'b0}};
            rx_q     <= {FRAME_BITS{1'b0}};
        end else if (start_i) begin
            active_q <= 1'b1;
            sck_q    <= 1'b0;
            sdi_q    <= cfg_i[CFG_BITS-1];
            tx_q     <= {cfg_i[CFG_BITS-2:0], {(FRAME_BITS-CFG_BITS){1'b0}}};
            phase_q  <= PHASE_RELOAD;
            bit_q    <= {BW{1'b0}};
            rx_q     <= {FRAME_BITS{1'b0}};
        end else if (active_q) begin
            if (phase_q != {PW{1'b0}}) begin
                phase_q <= phase_q - PW'(1);
            end else if (!sck_q) begin
                sck_q   <= 1'b1;
                rx_q    <= {rx_q[FRAME_BITS-2:0], sdo_i};
                phase_q <= PHASE_RELOAD;
            end else if (bit_q == LAST_BIT) begin
                // Frame complete: park SCK and SDI low.
                sck_q    <= 1'b0;
                sdi_q    <= 1'b0;
                active_q <= 1'b0;
            end else begin
                sck_q   <= 1'b0;
                sdi_q   <= tx_q[FRAME_BITS-2];
                tx_q    <= {tx_q[FRAME_BITS-3:0], 1'b0};
                bit_q   <= bit_q + BW'(1);
                phase_q <= PHASE_RELOAD;
            end
        end
    end

endmodule

// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 conversion controller. Accepts one request at a time and runs
// CONV -> SHIFT -> ACQ frames. Because the ADC applies a config word to
// the following conversion, a discarded priming frame is inserted whenever
// the requested config differs from the one last loaded into the ADC.
module adc_ltc2308_ctrl
    import adc_ltc2308_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int ACQ_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_ch,
    input  logic        req_sgl,
    input  logic        req_uni,
    output logic        res_valid,
    output logic [11:0] res_data,
    output logic [2:0]  res_ch,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int CNT_MAX = (CONV_CYCLES > ACQ_CYCLES) ? CONV_CYCLES : ACQ_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [2:0]            ch_q;
    logic [CFG_BITS-1:0]   cfg_q;
    logic                  prime_q;
    logic                  loaded_valid_q;
    logic [CFG_BITS-1:0]   loaded_cfg_q;
    logic                  req_ready_q;
    logic                  res_valid_q;
    logic [FRAME_BITS-1:0] res_data_q;
    logic [2:0]            res_ch_q;
    logic                  convst_q;

    logic [CFG_BITS-1:0]   req_cfg_s;
    logic                  need_prime_s;
    logic                  shift_start_s;
    logic                  shift_done_s;
    logic                  sck_s;
    logic                  sdi_s;
    logic [FRAME_BITS-1:0] rx_data_s;

    assign req_cfg_s     = pack_cfg(req_ch, req_sgl, req_uni);
    assign need_prime_s  = !loaded_valid_q || (req_cfg_s != loaded_cfg_q);
    assign shift_start_s = (state_q == CONV) && (cnt_q == {CW{1'b0}});

    ltc2308_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (shift_start_s),
        .cfg_i     (cfg_q),
        .sdo_i     (adc_sdo),
        .done_o    (shift_done_s),
        .sck_o     (sck_s),
        .sdi_o     (sdi_s),
        .rx_data_o (rx_data_s)
    );

    assign req_ready  = req_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_ch     = res_ch_q;
    assign adc_convst = convst_q;
    assign adc_sck    = sck_s;
    assign adc_sdi    = sdi_s;

    // Frame FSM, config tracking and registered request/result handshakes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= {CW{1'b0}};
            ch_q           <= 3'd0;
            cfg_q          <= {CFG_BITS{1'b0}};
            prime_q        <= 1'b0;
            loaded_valid_q <= 1'b0;
            loaded_cfg_q   <= {CFG_BITS{1'b0}};
            req_ready_q    <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= {FRAME_BITS{1'b0}};
            res_ch_q       <= 3'd0;
            convst_q       <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        ch_q        <= req_ch;
                        cfg_q       <= req_cfg_s;
                        prime_q     <= need_prime_s;
                        req_ready_q <= 1'b0;
                        convst_q    <= 1'b1;
                        cnt_q       <= CW'(CONV_CYCLES - 1);
                        state_q     <= CONV;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                CONV: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        // Shifter is started by the same condition this edge.
                        convst_q <= 1'b0;
                        state_q  <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SHIFT: begin
                    if (shift_done_s) begin
                        loaded_cfg_q   <= cfg_q;
                        loaded_valid_q <= 1'b1;
                        cnt_q          <= CW'(ACQ_CYCLES - 1);
                        state_q        <= ACQ;
                    end
                end
                ACQ: begin
                    if (cnt_q != {CW{1'b0}}) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (prime_q) begin
                        // Priming result is dropped; run the real measurement.
                        prime_q  <= 1'b0;
                        convst_q <= 1'b1;
                        cnt_q    <= CW'(CONV_CYCLES - 1);
                        state_q  <= CONV;
                    end else begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= rx_data_s;
                        res_ch_q    <= ch_q;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    convst_q    <= 1'b0;
                    req_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Directed bench for adc_ltc2308_ctrl: one instance at default parameters
// and one with CLK_DIV=1, each with an LTC2308-like SDO model that shifts a
// chosen 12-bit word out MSB first, advancing on each falling SCK.
module tb_adc_ltc2308_ctrl;

    localparam int CONV = 80;

    typedef struct {
        int         sel;
        logic [2:0] ch;
        logic       sgl;
        logic       uni;
        logic [11:0] word;
        logic       hold;
        int         lat;
        int         frames;
        logic [5:0] sdi6;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid_v, req_ready_v, req_sgl_v, req_uni_v, res_valid_v;
    logic [1:0]  convst_v, sck_v, sdi_v, sdo_v;
    logic [2:0]  req_ch_a   [2];
    logic [11:0] res_data_a [2];
    logic [2:0]  res_ch_a   [2];
    logic [11:0] sdo_word_a [2];

    int total = 0;
    int bad   = 0;
    vec_t vecs [14];

    int          m_lat, m_frames, m_wait, m_ready_bad, m_sck_bad, m_max_hi;
    int          m_conv_len [3];
    int          m_rises    [3];
    logic [11:0] m_sdi      [3];
    logic [11:0] m_data;
    logic [2:0]  m_ch;
    logic        m_start_ok, m_sck_res, m_ready_res;

    adc_ltc2308_ctrl u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_ch(req_ch_a[0]), .req_sgl(req_sgl_v[0]), .req_uni(req_uni_v[0]),
        .res_valid(res_valid_v[0]), .res_data(res_data_a[0]), .res_ch(res_ch_a[0]),
        .adc_convst(convst_v[0]), .adc_sck(sck_v[0]), .adc_sdi(sdi_v[0]), .adc_sdo(sdo_v[0])
    );

    adc_ltc2308_ctrl #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_ch(req_ch_a[1]), .req_sgl(req_sgl_v[1]), .req_uni(req_uni_v[1]),
        .res_valid(res_valid_v[1]), .res_data(res_data_a[1]), .res_ch(res_ch_a[1]),
        .adc_convst(convst_v[1]), .adc_sck(sck_v[1]), .adc_sdi(sdi_v[1]), .adc_sdo(sdo_v[1])
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ADC SDO models: MSB after CONVST rises, next bit after each SCK fall.
    for (genvar g = 0; g < 2; g++) begin : g_sdo
        int nfall;
        always @(posedge convst_v[g] or negedge sck_v[g]) begin
            if (convst_v[g]) nfall <= 0;
            else if (nfall < 11) nfall <= nfall + 1;
        end
        assign sdo_v[g] = sdo_word_a[g][11 - nfall];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge and monitor until res_valid (bounded).
    task automatic run_req(input vec_t v);
        int s, f, hi;
        logic pc, ps, cv, sk;
        s = v.sel;
        m_lat = -1; m_frames = 0; m_wait = 0; m_ready_bad = 0; m_sck_bad = 0;
        m_max_hi = 0; m_start_ok = 1'b0; m_sck_res = 1'b1; m_ready_res = 1'b0;
        m_data = 12'h000; m_ch = 3'd0;
        for (int i = 0; i < 3; i++) begin
            m_conv_len[i] = 0; m_rises[i] = 0; m_sdi[i] = 12'h000;
        end
        sdo_word_a[s] = v.word;
        req_ch_a[s] = v.ch; req_sgl_v[s] = v.sgl; req_uni_v[s] = v.uni;
        req_valid_v[s] = 1'b1;
        while (!req_ready_v[s] && m_wait < 20) begin
            @(negedge clk);
            m_wait++;
        end
        if (!req_ready_v[s]) begin
            chk("accept", int'(req_ready_v[s]), 1);
            req_valid_v[s] = 1'b0;
            return;
        end
        @(posedge clk);
        f = -1; hi = 0; pc = 1'b0; ps = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            cv = convst_v[s];
            sk = sck_v[s];
            if (cyc == 1) begin
                m_start_ok = cv && !req_ready_v[s];
                if (!v.hold) begin
                    req_valid_v[s] = 1'b0;
                    req_ch_a[s] = ~v.ch; req_sgl_v[s] = ~v.sgl; req_uni_v[s] = ~v.uni;
                end
            end
            if (cv && !pc) begin
                m_frames++;
                if (f < 2) f++;
                m_conv_len[f] = 0; m_rises[f] = 0; m_sdi[f] = 12'h000;
            end
            if (cv && f >= 0) m_conv_len[f]++;
            if (cv && sk) m_sck_bad++;
            if (sk && !ps && f >= 0) begin
                m_rises[f]++;
                m_sdi[f] = {m_sdi[f][10:0], sdi_v[s]};
            end
            if (sk) hi++; else hi = 0;
            if (hi > m_max_hi) m_max_hi = hi;
            if (res_valid_v[s]) begin
                m_lat = cyc; m_data = res_data_a[s]; m_ch = res_ch_a[s];
                m_sck_res = sk; m_ready_res = req_ready_v[s];
                break;
            end
            if (req_ready_v[s]) m_ready_bad++;
            pc = cv; ps = sk;
        end
    endtask

    task automatic do_row(input vec_t v);
        int nf;
        run_req(v);
        chk("accept_wait", m_wait, 0);
        chk("conv_start", int'(m_start_ok), 1);
        chk("latency", m_lat, v.lat);
        chk("frames", m_frames, v.frames);
        nf = (m_frames < 3) ? m_frames : 3;
        for (int f = 0; f < nf; f++) begin
            chk("convst_len", m_conv_len[f], CONV);
            chk("sck_rises", m_rises[f], 12);
            chk("sdi_frame", int'(m_sdi[f]), int'({v.sdi6, 6'b000000}));
        end
        chk("sck_high_run", m_max_hi, (v.sel == 1) ? 1 : 2);
        chk("ready_low_in_frame", m_ready_bad, 0);
        chk("ready_at_res", int'(m_ready_res), 1);
        chk("sck_idle_low", m_sck_bad + int'(m_sck_res), 0);
        chk("res_data", int'(m_data), int'(v.word));
        chk("res_ch", int'(m_ch), int'(v.ch));
        if (!v.hold) begin
            @(negedge clk);
            chk("res_valid_pulse", int'(res_valid_v[v.sel]), 0);
            chk("res_data_hold", int'(res_data_a[v.sel]), int'(v.word));
        end
    endtask

    initial begin
        // sel, ch, sgl, uni, sdo word, hold valid, latency, frames, SDI cfg
        vecs[0]  = '{0, 3'd0, 1'b1, 1'b1, 12'hA5C, 1'b0, 281, 2, 6'b100010};
        vecs[1]  = '{0, 3'd0, 1'b1, 1'b1, 12'h123, 1'b0, 141, 1, 6'b100010};
        vecs[2]  = '{0, 3'd5, 1'b1, 1'b0, 12'h5A3, 1'b0, 281, 2, 6'b111000};
        vecs[3]  = '{0, 3'd5, 1'b1, 1'b0, 12'hFFF, 1'b0, 141, 1, 6'b111000};
        vecs[4]  = '{0, 3'd5, 1'b0, 1'b0, 12'h000, 1'b0, 281, 2, 6'b011000};
        vecs[5]  = '{0, 3'd3, 1'b0, 1'b1, 12'h801, 1'b0, 281, 2, 6'b010110};
        vecs[6]  = '{0, 3'd3, 1'b0, 1'b1, 12'h7FE, 1'b0, 141, 1, 6'b010110};
        vecs[7]  = '{0, 3'd3, 1'b0, 1'b1, 12'h9C3, 1'b1, 141, 1, 6'b010110};
        vecs[8]  = '{0, 3'd3, 1'b0, 1'b1, 12'h36A, 1'b1, 141, 1, 6'b010110};
        vecs[9]  = '{0, 3'd3, 1'b0, 1'b1, 12'hC81, 1'b0, 141, 1, 6'b010110};
        vecs[10] = '{1, 3'd0, 1'b1, 1'b1, 12'hFFF, 1'b0, 233, 2, 6'b100010};
        vecs[11] = '{1, 3'd0, 1'b1, 1'b1, 12'h000, 1'b0, 117, 1, 6'b100010};
        vecs[12] = '{1, 3'd0, 1'b1, 1'b1, 12'hFFF, 1'b0, 117, 1, 6'b100010};
        vecs[13] = '{0, 3'd3, 1'b0, 1'b1, 12'h3C5, 1'b0, 281, 2, 6'b010110};

        reset_n = 1'b0;
        req_valid_v = 2'b00; req_sgl_v = 2'b00; req_uni_v = 2'b00;
        for (int s = 0; s < 2; s++) begin
            req_ch_a[s] = 3'd0;
            sdo_word_a[s] = 12'h000;
        end

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", int'(req_ready_v[s]), 0);
            chk("rst_outputs", int'({res_valid_v[s], convst_v[s], sck_v[s], sdi_v[s]}), 0);
            chk("rst_res_data", int'(res_data_a[s]), 0);
        end
        reset_n = 1'b1;
        chk("ready_before_edge", int'(req_ready_v[0]), 0);
        @(negedge clk);
        chk("ready_after_edge", int'(req_ready_v), 3);
        @(negedge clk);

        for (int i = 0; i < 10; i++) do_row(vecs[i]);

        // Abort a same-config request mid-SHIFT (bit 1 high phase, SDI=1).
        sdo_word_a[0] = 12'h3C5;
        req_ch_a[0] = 3'd3; req_sgl_v[0] = 1'b0; req_uni_v[0] = 1'b1;
        req_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        repeat (86) @(negedge clk);
        chk("pre_rst_sck", int'(sck_v[0]), 1);
        chk("pre_rst_sdi", int'(sdi_v[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_pins", int'({convst_v[0], sck_v[0], sdi_v[0]}), 0);
        chk("async_rst_res_valid", int'(res_valid_v[0]), 0);
        chk("async_rst_ready", int'(req_ready_v[0]), 0);
        chk("async_rst_res", int'({res_ch_a[0], res_data_a[0]}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", int'(req_ready_v[0]), 1);

        for (int i = 10; i < 14; i++) do_row(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
